history_trigger_dump: RTL and testbench
=======================================

// Module: history_trigger_dump
// PURPOSE
//   Downstream consumer of the signal_history shift array in the pipelined RISC-V debug path.
//   When armed, it watches the newest history entry for a masked match. After POST_TRIG further
//   cycles it freezes a DEPTH-entry snapshot of the history array. It then streams the snapshot
//   oldest-first over a valid/ready port to the trace sink.
// PARAMETERS
//   WIDTH      8   width of one history entry
//   DEPTH      16  entries in hist_in; must match the upstream history depth
//   POST_TRIG  4   cycles captured after the trigger; legal range 0..DEPTH-2
//   IDXW (localparam) = $clog2(DEPTH)
// PORTS
//   clk        in   1              clock; all state updates on posedge
//   rst        in   1              synchronous, active-high reset
//   hist_in    in   WIDTH x DEPTH  history array; [0] is the newest entry, shifts every clk
//   arm        in   1              request to arm the trigger; sampled only in IDLE
//   abort      in   1              cancel arm or wait; effective in IDLE/ARMED/POST
//   trig_value in   WIDTH          value to compare against
//   trig_mask  in   WIDTH          compare mask; 1 = bit participates
//   out_valid  out  1              snapshot word available
//   out_ready  in   1              sink accepts the word
//   out_data   out  WIDTH          snapshot word
//   out_index  out  IDXW           word number, 0 = oldest
//   out_last   out  1              final word of the dump
//   busy       out  1              state != IDLE
//   done       out  1              one-cycle pulse after the last transfer
// BEHAVIOUR
// - Reset, at the posedge with rst=1:
//   - state=IDLE; post counter, dump counter and all snapshot regs cleared
//   - outputs: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0
//   - Reset in any state, including mid-dump, discards the dump. No further words are output.
// - States: IDLE, ARMED, POST, DUMP.
// - IDLE -> ARMED when arm=1 and abort=0. With arm=1 and abort=1 the block stays in IDLE.
// - ARMED:
//   - Match = ((hist_in[0] ^ trig_value) & trig_mask) == 0.
//   - On a match: post counter <= POST_TRIG; go to POST. abort=1 -> IDLE; abort wins over a match.
//   - trig_mask=0 matches on the first ARMED cycle.
// - POST:
//   - If counter != 0, decrement it.
//   - If counter == 0: snap[i] <= hist_in[i] for all i; dump counter <= 0; go to DUMP.
//   - abort=1 -> IDLE with no snapshot taken.
//   - Resulting layout: the trigger entry sits at snap[POST_TRIG+1], i.e. out_index DEPTH-2-POST_TRIG.
// - DUMP:
//   - out_valid=1
//   - out_data = snap[DEPTH-1-cnt]
//   - out_index = cnt
//   - out_last = (cnt == DEPTH-1)
//   - Transfer = out_valid & out_ready; each transfer increments cnt.
//   - While out_ready=0, out_data, out_index and out_last hold stable. out_valid never drops mid-dump.
//   - Transfer with out_last=1 -> IDLE; done=1 in the following cycle only.
//   - abort and arm are ignored in DUMP.
// - Outputs when not in DUMP: out_valid=0, out_data=0, out_index=0, out_last=0.
// - No combinational path from hist_in or trig_* to any output.
// - Latency:
//   - Match edge -> snapshot edge = POST_TRIG+1 cycles.
//   - Snapshot edge -> first out_valid = 0 cycles; out_valid is high in the cycle after the snapshot.
// - Throughput: 1 word/cycle with out_ready held high; a full dump takes DEPTH cycles.
// TESTING (WIDTH=8, DEPTH=16, POST_TRIG=4, upstream history fed with a ramp 0x01,0x02,...)
// 1. Hold rst 2 cycles -> out_valid=0, busy=0, done=0, out_data=0. Re-assert rst with no arm -> state stays IDLE.
// 2. Trigger: value=0x20, mask=0xFF, out_ready=1 -> 16 words 0x16..0x25, index 0..15.
//    Word 0x20 at index 10, out_last on 0x25, done pulse 1 cycle later.
// 3. Backpressure as in 2, with out_ready toggling 1,0,1,0 -> words stable while ready=0.
//    Exactly 16 transfers, same data sequence.
// 4. Masked match: mask=0xF0, value=0x30, arm while ramp < 0x30 -> trigger at 0x30, dump 0x26..0x35.
// 5. abort: abort 2 cycles into POST -> IDLE with no out_valid. arm=1 with abort=1 in IDLE -> busy stays 0.
// 6. Reset mid-dump: rst after the 7th transfer -> out_valid=0 next cycle.
//    Re-arm then produces a complete 16-word dump.

Source files
------------

// File: rtl/history_trigger_dump.sv
// Arms on a masked match against the newest history entry, waits POST_TRIG cycles,
// freezes the whole history array and streams it oldest-first to the trace sink.
module history_trigger_dump #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int IDXW     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][WIDTH-1:0] hist_in,
  input  logic                        arm,
  input  logic                        abort,
  input  logic [WIDTH-1:0]            trig_value,
  input  logic [WIDTH-1:0]            trig_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [IDXW-1:0]             out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DUMP  = 2'd3;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  logic [1:0]                  state_q, state_d;
  logic [IDXW-1:0]             post_q, post_d;
  logic [IDXW-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] snap_q, snap_d;
  logic                        done_q, done_d;
  logic                        match;
  logic [IDXW-1:0]             rd_idx;

  assign match = ((hist_in[0] ^ trig_value) & trig_mask) == '0;

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm && !abort) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          post_d  = IDXW'(POST_TRIG);
          state_d = S_POST;
        end
      end
      S_POST: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (post_q != '0) begin
          post_d = post_q - 1'b1;
        end else begin
          // Trigger entry has aged to index POST_TRIG+1 by the time it is frozen.
          snap_d  = hist_in;
          cnt_d   = '0;
          state_d = S_DUMP;
        end
      end
      default: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      post_q  <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  // Output handshake: a word moves when out_valid && out_ready at posedge; while
  // out_ready is low the word, index and last flag are held and out_valid stays high.
  assign rd_idx    = LAST_IDX - cnt_q;
  assign out_valid = (state_q == S_DUMP);
  assign out_data  = out_valid ? snap_q[rd_idx] : '0;
  assign out_index = out_valid ? cnt_q : '0;
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_history_trigger_dump.sv
// Bench for history_trigger_dump: ramp-fed table vectors, abort/reset sequences and
// randomized triggers checked against a history-queue reference model.
module tb_history_trigger_dump;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;
  localparam int IDXW      = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [DEPTH-1:0][WIDTH-1:0] hist_in;
  logic                        arm, abort;
  logic [WIDTH-1:0]            trig_value, trig_mask;
  logic                        out_valid, out_ready;
  logic [WIDTH-1:0]            out_data;
  logic [IDXW-1:0]             out_index;
  logic                        out_last, busy, done;
  logic [1:0]                  dbg_state;

  history_trigger_dump #(.WIDTH(WIDTH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst), .hist_in(hist_in), .arm(arm), .abort(abort),
    .trig_value(trig_value), .trig_mask(trig_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic             ramp_mode;
  logic [WIDTH-1:0] hist_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] act_data[$];
  logic [IDXW-1:0]  act_idx[$];
  logic             act_last[$];

  typedef struct {
    logic [7:0] start;
    logic [7:0] tval;
    logic [7:0] tmask;
    logic [7:0] first;
    int         mode;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_hist();
    for (int k = 0; k < DEPTH; k++) hist_in[k] = hist_q[hist_q.size() - 1 - k];
  endtask

  task automatic load_ramp(input logic [7:0] newest);
    hist_q.delete();
    for (int k = DEPTH - 1; k >= 0; k--) hist_q.push_back(newest - 8'(k));
    ramp_mode = 1'b1;
    drive_hist();
  endtask

  // Upstream history shifts once per clock; new entry appears just after the edge.
  task automatic tick();
    logic [7:0] nv;
    @(posedge clk);
    #1;
    if (ramp_mode) nv = hist_q[hist_q.size() - 1] + 8'd1;
    else nv = 8'($urandom);
    hist_q.push_back(nv);
    drive_hist();
  endtask

  task automatic arm_pulse(output int a);
    arm = 1'b1;
    a = hist_q.size() - 1;
    tick();
    arm = 1'b0;
    check("armed_busy", busy, 1);
  endtask

  task automatic collect(input int mode, input int max_n, output int n);
    int   k;
    bit   stall, seen, finished, last_xfer;
    logic [7:0] pd;
    logic [IDXW-1:0] pi;
    logic pl;
    n = 0; k = 0; stall = 0; seen = 0; finished = 0; last_xfer = 0;
    pd = '0; pi = '0; pl = 1'b0;
    act_data.delete(); act_idx.delete(); act_last.delete();
    for (int c = 0; c < 100; c++) begin
      if (out_valid) begin seen = 1; break; end
      tick();
    end
    check("valid_timeout", seen, 1);
    if (!seen) return;
    for (int c = 0; c < 300; c++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
      check("valid_held", out_valid, 1);
      if (stall) begin
        check("hold_data", out_data, pd);
        check("hold_index", out_index, pi);
        check("hold_last", out_last, pl);
      end
      pd = out_data; pi = out_index; pl = out_last;
      stall = !out_ready;
      last_xfer = out_ready && out_last;
      if (out_ready) begin
        act_data.push_back(out_data);
        act_idx.push_back(out_index);
        act_last.push_back(out_last);
        n++;
      end
      tick();
      if (last_xfer || n == max_n) begin finished = 1; break; end
    end
    out_ready = 1'b0;
    check("dump_timeout", finished, 1);
    if (last_xfer) begin
      check("done_pulse", done, 1);
      check("idle_after_dump", busy, 0);
      check("valid_after_dump", out_valid, 0);
      tick();
      check("done_one_cycle", done, 0);
    end
  endtask

  task automatic compare_words(input int n);
    for (int i = 0; i < n; i++) begin
      check("word_data", act_data[i], exp_q[i]);
      check("word_index", act_idx[i], 32'(i));
      check("word_last", act_last[i], (i == DEPTH - 1));
    end
  endtask

  task automatic run_vec(input vec_t v, input int max_n);
    int a, n;
    load_ramp(v.start);
    trig_value = v.tval;
    trig_mask  = v.tmask;
    arm_pulse(a);
    collect(v.mode, max_n, n);
    check("word_count", n, max_n);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(v.first + 8'(i));
    compare_words(n);
  endtask

  initial begin
    int a, n, m, s, found, saw_valid;
    logic [7:0] mk;
    vecs[0] = '{start: 8'h10, tval: 8'h20, tmask: 8'hFF, first: 8'h16, mode: 0};
    vecs[1] = '{start: 8'h10, tval: 8'h20, tmask: 8'hFF, first: 8'h16, mode: 1};
    vecs[2] = '{start: 8'h28, tval: 8'h30, tmask: 8'hF0, first: 8'h26, mode: 0};
    vecs[3] = '{start: 8'h05, tval: 8'h0A, tmask: 8'h0F, first: 8'h00, mode: 1};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; out_ready = 1'b0;
    trig_value = '0; trig_mask = '0;
    load_ramp(8'h01);
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("rst_again_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], DEPTH);

    // Abort two cycles into the post-trigger wait.
    load_ramp(8'h10);
    trig_value = 8'h20; trig_mask = 8'hFF;
    arm_pulse(a);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (hist_q[hist_q.size() - 2] == 8'h20) begin found = 1; break; end
      tick();
    end
    check("abort_match_seen", found, 1);
    tick(); tick();
    check("post_state", dbg_state, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    saw_valid = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) saw_valid = 1;
      tick();
    end
    check("abort_no_valid", saw_valid, 0);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", busy, 0);

    // Reset after the 7th transfer discards the rest of the dump.
    run_vec(vecs[0], 7);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", out_data, 0);
    tick();
    check("midrst_stays_idle", out_valid, 0);
    run_vec(vecs[0], DEPTH);

    // Random history and triggers against the queue model.
    ramp_mode = 1'b0;
    hist_q.delete();
    for (int k = 0; k < DEPTH; k++) hist_q.push_back(8'($urandom));
    drive_hist();
    for (int it = 0; it < 8; it++) begin
      mk = (8'h1 << $urandom_range(0, 7)) | (8'h1 << $urandom_range(0, 7));
      trig_mask  = mk;
      trig_value = 8'($urandom);
      arm_pulse(a);
      collect(2, DEPTH, n);
      check("rnd_count", n, DEPTH);
      m = -1;
      for (int j = a + 1; j < hist_q.size(); j++) begin
        if (((hist_q[j] ^ trig_value) & trig_mask) == 8'h00) begin m = j; break; end
      end
      s = m + POST_TRIG + 1;
      check("rnd_model_match", (m >= 0 && s < hist_q.size()), 1);
      if (m >= 0 && s < hist_q.size()) begin
        exp_q.delete();
        for (int i = s - (DEPTH - 1); i <= s; i++) exp_q.push_back(hist_q[i]);
        compare_words(n);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
